// File: rtl/pqr5_regfile_pkg.sv
// rtl/pqr5_regfile_pkg.sv - shared types and constants for the register-file front-end controller
package pqr5_regfile_pkg;

    // Controller phase: INIT clears the RAM after reset, RUN serves requests.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_state_t;

    // Source of a read port's output data for the cycle after a read.
    typedef enum logic [1:0] {
        SEL_ZERO = 2'd0,
        SEL_BYP  = 2'd1,
        SEL_RAM  = 2'd2
    } rf_sel_t;

    // Hardwired-zero register index.
    localparam int unsigned REG_X0 = 0;

endpackage

// File: rtl/pqr5_rf_rdport.sv
// rtl/pqr5_rf_rdport.sv - one read port: select/bypass register and output mux
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   load          a read is accepted this cycle (RUN and i_rden)
//   raddr         read address for this port
//   wren, waddr,  same-cycle write request, used for forwarding
//   wdata
//   bram_rdata    RAM read data for this port (1-cycle sync read)
//   rdata         read data presented to decode
module pqr5_rf_rdport
    import pqr5_regfile_pkg::*;
#(
    parameter int DTW = 32,
    parameter int ADW = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [ADW-1:0] raddr,
    input  logic           wren,
    input  logic [ADW-1:0] waddr,
    input  logic [DTW-1:0] wdata,
    input  logic [DTW-1:0] bram_rdata,
    output logic [DTW-1:0] rdata
);

    localparam logic [ADW-1:0] X0 = ADW'(REG_X0);

    rf_sel_t        sel;
    logic [DTW-1:0] byp_data;

    // The select is only updated on an accepted read, so both sel and
    // byp_data hold while i_rden is low; together with the RAM holding its
    // read register this keeps rdata stable between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel      <= SEL_ZERO;
            byp_data <= '0;
        end else if (load) begin
            if (raddr == X0) begin
                sel <= SEL_ZERO;
            end else if (wren && (waddr == raddr)) begin
                // The RAM's read-during-write result is undefined for us, so
                // capture the write data and serve it from here.
                sel      <= SEL_BYP;
                byp_data <= wdata;
            end else begin
                sel <= SEL_RAM;
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (sel)
            SEL_BYP: rdata = byp_data;
            SEL_RAM: rdata = bram_rdata;
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/pqr5_regfile_ctrl.sv
// rtl/pqr5_regfile_ctrl.sv - register-file front end: post-reset clear, x0 hardwiring, write forwarding
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   o_ready                  clear finished, requests accepted
//   i_wren/i_waddr/i_wdata   writeback write request
//   i_rden/i_raddr0/1        decode read request (shared enable)
//   o_rdata0/1               read data, one cycle after i_rden
//   o_bram_*                 RAM write and read control
//   i_bram_rdata0/1          RAM read data, 1-cycle sync read
module pqr5_regfile_ctrl
    import pqr5_regfile_pkg::*;
#(
    parameter  int DTW  = 32,
    parameter  int NREG = 32,
    localparam int ADW  = $clog2(NREG)
) (
    input  logic           clk,
    input  logic           rst,
    output logic           o_ready,
    input  logic           i_wren,
    input  logic [ADW-1:0] i_waddr,
    input  logic [DTW-1:0] i_wdata,
    input  logic           i_rden,
    input  logic [ADW-1:0] i_raddr0,
    input  logic [ADW-1:0] i_raddr1,
    output logic [DTW-1:0] o_rdata0,
    output logic [DTW-1:0] o_rdata1,
    output logic           o_bram_wren,
    output logic [ADW-1:0] o_bram_waddr,
    output logic [DTW-1:0] o_bram_wdata,
    output logic           o_bram_rden,
    output logic [ADW-1:0] o_bram_raddr0,
    output logic [ADW-1:0] o_bram_raddr1,
    input  logic [DTW-1:0] i_bram_rdata0,
    input  logic [DTW-1:0] i_bram_rdata1
);

    localparam logic [ADW-1:0] X0      = ADW'(REG_X0);
    // One bit wider than an address so the count can reach NREG itself.
    localparam logic [ADW:0]   CLR_END = (ADW+1)'(NREG);

    rf_state_t    state, state_nxt;
    logic [ADW:0] clr_cnt, clr_nxt;
    logic         rd_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= INIT;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_nxt;
        end
    end

    // RAM outputs are masked while rst is high so nothing is written or read
    // until the clear actually starts on the first cycle after rst falls.
    always_comb begin
        state_nxt    = state;
        clr_nxt      = clr_cnt;
        o_ready      = 1'b0;
        o_bram_wren  = 1'b0;
        o_bram_waddr = i_waddr;
        o_bram_wdata = i_wdata;
        o_bram_rden  = 1'b0;
        rd_load      = 1'b0;
        case (state)
            INIT: begin
                o_bram_wren  = !rst;
                o_bram_waddr = clr_cnt[ADW-1:0];
                o_bram_wdata = '0;
                clr_nxt      = clr_cnt + 1'b1;
                if (clr_nxt == CLR_END) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                o_ready     = 1'b1;
                o_bram_wren = !rst && i_wren && (i_waddr != X0);
                o_bram_rden = !rst && i_rden;
                rd_load     = i_rden;
            end
            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    assign o_bram_raddr0 = i_raddr0;
    assign o_bram_raddr1 = i_raddr1;

    pqr5_rf_rdport #(.DTW(DTW), .ADW(ADW)) u_rdport0 (
        .clk        (clk),
        .rst        (rst),
        .load       (rd_load),
        .raddr      (i_raddr0),
        .wren       (i_wren),
        .waddr      (i_waddr),
        .wdata      (i_wdata),
        .bram_rdata (i_bram_rdata0),
        .rdata      (o_rdata0)
    );

    pqr5_rf_rdport #(.DTW(DTW), .ADW(ADW)) u_rdport1 (
        .clk        (clk),
        .rst        (rst),
        .load       (rd_load),
        .raddr      (i_raddr1),
        .wren       (i_wren),
        .waddr      (i_waddr),
        .wdata      (i_wdata),
        .bram_rdata (i_bram_rdata1),
        .rdata      (o_rdata1)
    );

endmodule

// File: tb/tb_pqr5_regfile_ctrl.sv
// tb/tb_pqr5_regfile_ctrl.sv - scoreboard bench for pqr5_regfile_ctrl
module tb_pqr5_regfile_ctrl;

    localparam int DTW  = 32;
    localparam int NREG = 32;
    localparam int ADW  = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           o_ready;
    logic           i_wren = 1'b0;
    logic [ADW-1:0] i_waddr = '0;
    logic [DTW-1:0] i_wdata = '0;
    logic           i_rden = 1'b0;
    logic [ADW-1:0] i_raddr0 = '0;
    logic [ADW-1:0] i_raddr1 = '0;
    logic [DTW-1:0] o_rdata0, o_rdata1;
    logic           o_bram_wren;
    logic [ADW-1:0] o_bram_waddr;
    logic [DTW-1:0] o_bram_wdata;
    logic           o_bram_rden;
    logic [ADW-1:0] o_bram_raddr0, o_bram_raddr1;
    logic [DTW-1:0] i_bram_rdata0 = '0;
    logic [DTW-1:0] i_bram_rdata1 = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pqr5_regfile_ctrl #(.DTW(DTW), .NREG(NREG)) dut (
        .clk           (clk),
        .rst           (rst),
        .o_ready       (o_ready),
        .i_wren        (i_wren),
        .i_waddr       (i_waddr),
        .i_wdata       (i_wdata),
        .i_rden        (i_rden),
        .i_raddr0      (i_raddr0),
        .i_raddr1      (i_raddr1),
        .o_rdata0      (o_rdata0),
        .o_rdata1      (o_rdata1),
        .o_bram_wren   (o_bram_wren),
        .o_bram_waddr  (o_bram_waddr),
        .o_bram_wdata  (o_bram_wdata),
        .o_bram_rden   (o_bram_rden),
        .o_bram_raddr0 (o_bram_raddr0),
        .o_bram_raddr1 (o_bram_raddr1),
        .i_bram_rdata0 (i_bram_rdata0),
        .i_bram_rdata1 (i_bram_rdata1)
    );

    // RAM model: power-up contents are junk; a read colliding with a write
    // returns 0 so only the controller's forwarding can produce new data.
    logic [DTW-1:0] mem [NREG];
    initial begin
        for (int i = 0; i < NREG; i++) mem[i] = $urandom;
    end
    always @(posedge clk) begin
        if (o_bram_rden) begin
            i_bram_rdata0 <= (o_bram_wren && o_bram_waddr == o_bram_raddr0) ? '0 : mem[o_bram_raddr0];
            i_bram_rdata1 <= (o_bram_wren && o_bram_waddr == o_bram_raddr1) ? '0 : mem[o_bram_raddr1];
        end
        if (o_bram_wren) mem[o_bram_waddr] <= o_bram_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural register contents. Every read returns
    // the register value including any write made in the same cycle; x0 is
    // never written so it always reads 0.
    logic [DTW-1:0]   ref_mem [NREG];
    logic [2*DTW-1:0] exp_q [$];

    task automatic ref_clear();
        for (int i = 0; i < NREG; i++) ref_mem[i] = '0;
    endtask

    // One RUN cycle of stimulus; called at posedge+1, returns at next posedge+1.
    task automatic drive(input logic we, input logic [ADW-1:0] wa, input logic [DTW-1:0] wd,
                         input logic re, input logic [ADW-1:0] a0, input logic [ADW-1:0] a1);
        i_wren = we; i_waddr = wa; i_wdata = wd;
        i_rden = re; i_raddr0 = a0; i_raddr1 = a1;
        if (we && wa != 0) ref_mem[wa] = wd;
        if (re) exp_q.push_back({ref_mem[a0], ref_mem[a1]});
        #1;
        check("run_ready", 32'(o_ready), 32'd1);
        check("run_bram_wren", 32'(o_bram_wren), 32'(we && wa != 0));
        check("run_bram_rden", 32'(o_bram_rden), 32'(re));
        check("run_bram_raddr0", 32'(o_bram_raddr0), 32'(a0));
        check("run_bram_raddr1", 32'(o_bram_raddr1), 32'(a1));
        if (we && wa != 0) begin
            check("run_bram_waddr", 32'(o_bram_waddr), 32'(wa));
            check("run_bram_wdata", o_bram_wdata, wd);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        i_wren = 1'b0; i_waddr = '0; i_wdata = '0;
        i_rden = 1'b0; i_raddr0 = '0; i_raddr1 = '0;
    endtask

    task automatic apply_reset(input int ncyc);
        idle();
        rst = 1'b1;
        repeat (ncyc) @(posedge clk);
        #1;
        check("rst_ready", 32'(o_ready), 32'd0);
        check("rst_bram_wren", 32'(o_bram_wren), 32'd0);
        check("rst_bram_rden", 32'(o_bram_rden), 32'd0);
        rst = 1'b0;
        ref_clear();
    endtask

    // Observe ncyc clear cycles; with junk=1 requests are thrown at the
    // controller and must be ignored.
    task automatic run_clear(input bit junk, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            if (junk) begin
                i_wren = 1'b1; i_waddr = 5'd3; i_wdata = $urandom;
                i_rden = 1'b1; i_raddr0 = 5'd3; i_raddr1 = 5'd3;
            end else begin
                idle();
            end
            #1;
            check("clr_wren", 32'(o_bram_wren), 32'd1);
            check("clr_waddr", 32'(o_bram_waddr), 32'(i));
            check("clr_wdata", o_bram_wdata, 32'd0);
            check("clr_rden", 32'(o_bram_rden), 32'd0);
            check("clr_ready", 32'(o_ready), 32'd0);
            @(posedge clk); #1;
        end
        idle();
    endtask

    task automatic check_ready_after_clear();
        #1;
        check("clear_done_ready", 32'(o_ready), 32'd1);
        check("clear_done_wren", 32'(o_bram_wren), 32'd0);
    endtask

    task automatic random_cycles(input int n);
        logic [ADW-1:0] wa, a0, a1;
        for (int k = 0; k < n; k++) begin
            wa = ($urandom_range(0, 3) == 0) ? ADW'($urandom) : ADW'($urandom_range(0, 3));
            a0 = ($urandom_range(0, 3) == 0) ? ADW'($urandom) : ADW'($urandom_range(0, 3));
            a1 = ($urandom_range(0, 3) == 0) ? ADW'($urandom) : ADW'($urandom_range(0, 3));
            drive(1'($urandom), wa, $urandom, 1'($urandom), a0, a1);
        end
    endtask

    // Monitor: o_rdata changes only one cycle after an accepted read (popped
    // from the scoreboard) or after reset (zero); otherwise it must hold.
    logic             rd_pend  = 1'b0;
    logic             rst_pend = 1'b1;
    logic [2*DTW-1:0] hold     = '0;
    always @(negedge clk) begin
        if (rst_pend) begin
            hold = '0;
        end else if (rd_pend) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_underflow: read data with no expected entry at %0t", $time);
            end else begin
                hold = exp_q.pop_front();
            end
        end
        check("rdata0", o_rdata0, hold[2*DTW-1:DTW]);
        check("rdata1", o_rdata1, hold[DTW-1:0]);
        rd_pend  = i_rden && o_ready && !rst;
        rst_pend = rst;
    end

    initial begin
        ref_clear();
        // Test 1: reset then full clear over all entries
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(o_ready), 32'd0);
        check("rst_bram_wren", 32'(o_bram_wren), 32'd0);
        check("rst_bram_rden", 32'(o_bram_rden), 32'd0);
        rst = 1'b0;
        run_clear(1'b0, NREG);
        check_ready_after_clear();

        // Test 2: same-cycle write/read on both ports is forwarded
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 5'd5);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);

        // Test 3: x0 write suppressed, reads of x0 return 0
        drive(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 5'd0);
        drive(1'b1, 5'd0, 32'h5678, 1'b1, 5'd0, 5'd0);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);

        // Test 4: sequential write/read, then hold while i_rden=0
        drive(1'b1, 5'd7, 32'h000000A5, 1'b0, 5'd0, 5'd0);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7);
        drive(1'b1, 5'd7, 32'h0000005A, 1'b0, 5'd7, 5'd7);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd7);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd7);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd5);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);

        random_cycles(400);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);

        // Test 5: reset mid-clear restarts from entry 0
        apply_reset(1);
        run_clear(1'b0, 10);
        apply_reset(1);
        run_clear(1'b0, NREG);
        check_ready_after_clear();
        random_cycles(150);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);

        // Test 6: requests during INIT are ignored
        apply_reset(2);
        run_clear(1'b1, NREG);
        check_ready_after_clear();
        for (int r = 0; r < NREG; r += 2) begin
            drive(1'b0, 5'd0, 32'h0, 1'b1, ADW'(r), ADW'(r + 1));
        end
        random_cycles(200);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);

        repeat (2) @(posedge clk);
        #1;
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
